// File: rtl/text_write_arbiter_if.sv
// Text RAM write arbiter bus: client write/clear requests,
// video-fetch arbitration input and the registered RAM port.
interface text_write_arbiter_if;
  logic        wr_req;
  logic [7:0]  wr_char;
  logic [7:0]  wr_x;
  logic [7:0]  wr_y;
  logic [7:0]  wr_attr1;
  logic [7:0]  wr_attr2;
  logic        clr_req;
  logic [7:0]  clr_attr1;
  logic [7:0]  clr_attr2;
  logic        vid_active;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [23:0] ram_data;
  logic        q_full;
  logic        overflow;
  logic        busy;
  logic        clr_done;

  modport master (
    output wr_req, wr_char, wr_x, wr_y,
    output wr_attr1, wr_attr2,
    output clr_req, clr_attr1, clr_attr2,
    output vid_active,
    input  ram_we, ram_addr, ram_data,
    input  q_full, overflow, busy, clr_done
  );

  modport slave (
    input  wr_req, wr_char, wr_x, wr_y,
    input  wr_attr1, wr_attr2,
    input  clr_req, clr_attr1, clr_attr2,
    input  vid_active,
    output ram_we, ram_addr, ram_data,
    output q_full, overflow, busy, clr_done
  );
endinterface

// File: rtl/text_write_arbiter.sv
// Queues character writes and full-screen clears into a text RAM,
// yielding every cycle the video fetch owns the RAM.
module text_write_arbiter #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int QDEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  text_write_arbiter_if.slave bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);
  localparam logic [11:0] LAST = 12'(COLS * ROWS - 1);

  typedef struct packed {
    logic [7:0] ch;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] a1;
    logic [7:0] a2;
  } entry_t;

  entry_t mem_q [QDEPTH];

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   clr_addr_q, clr_addr_d;
  logic [7:0]    clr_a1_q, clr_a1_d;
  logic [7:0]    clr_a2_q, clr_a2_d;
  logic          ram_we_q, ram_we_d;
  logic [11:0]   ram_addr_q, ram_addr_d;
  logic [23:0]   ram_data_q, ram_data_d;
  logic          ovf_q, ovf_d;
  logic          clr_last_q, clr_last_d;
  logic          clr_done_q, clr_done_d;

  entry_t      head;
  entry_t      wr_ent;
  logic        full;
  logic        pop;
  logic        push;
  logic        cell_ok;
  logic [11:0] cell_addr;

  always_comb begin
    wr_ent.ch = bus.wr_char;
    wr_ent.x  = bus.wr_x;
    wr_ent.y  = bus.wr_y;
    wr_ent.a1 = bus.wr_attr1;
    wr_ent.a2 = bus.wr_attr2;

    head = mem_q[rd_q];
    full = (cnt_q == FULL_CNT);

    // A clear flushes the queue, so nothing may pop alongside it.
    pop = (state_q == S_IDLE)
       && (cnt_q != '0)
       && !bus.vid_active
       && !bus.clr_req;

    push = bus.wr_req
        && (bus.clr_req || !full || pop);

    cell_ok = (12'(head.x) < 12'(COLS))
           && (12'(head.y) < 12'(ROWS));
    cell_addr = 12'(head.y) * 12'(COLS)
              + 12'(head.x);

    state_d    = state_q;
    rd_d       = rd_q;
    wr_d       = wr_q + AW'(push);
    cnt_d      = cnt_q;
    clr_addr_d = clr_addr_q;
    clr_a1_d   = clr_a1_q;
    clr_a2_d   = clr_a2_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ovf_d      = bus.wr_req && !push;
    clr_last_d = 1'b0;
    clr_done_d = clr_last_q;

    if (bus.clr_req) begin
      // Coincident write lands in the freshly emptied queue.
      rd_d       = wr_q;
      cnt_d      = CW'(push);
      state_d    = S_CLEAR;
      clr_addr_d = '0;
      clr_a1_d   = bus.clr_attr1;
      clr_a2_d   = bus.clr_attr2;
    end else begin
      rd_d  = rd_q + AW'(pop);
      cnt_d = cnt_q + CW'(push) - CW'(pop);

      if (pop && cell_ok) begin
        ram_we_d   = 1'b1;
        ram_addr_d = cell_addr;
        ram_data_d = {head.a2, head.a1, head.ch};
      end

      if (state_q == S_CLEAR && !bus.vid_active) begin
        ram_we_d   = 1'b1;
        ram_addr_d = clr_addr_q;
        ram_data_d = {clr_a2_q, clr_a1_q, 8'h20};
        if (clr_addr_q == LAST) begin
          state_d    = S_IDLE;
          clr_last_d = 1'b1;
        end else begin
          clr_addr_d = clr_addr_q + 12'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= wr_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      clr_addr_q <= '0;
      clr_a1_q   <= '0;
      clr_a2_q   <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ovf_q      <= 1'b0;
      clr_last_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      clr_addr_q <= clr_addr_d;
      clr_a1_q   <= clr_a1_d;
      clr_a2_q   <= clr_a2_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ovf_q      <= ovf_d;
      clr_last_q <= clr_last_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign bus.ram_we   = ram_we_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_data = ram_data_q;
  assign bus.q_full   = full;
  assign bus.overflow = ovf_q;
  assign bus.clr_done = clr_done_q;
  assign bus.busy     = (state_q == S_CLEAR)
                     || (cnt_q != '0);

endmodule

// File: tb/tb_text_write_arbiter.sv
// Bench for text_write_arbiter: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_text_write_arbiter;
  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int QDEPTH = 4;
  localparam int NCELL  = COLS * ROWS;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  text_write_arbiter_if bus();

  text_write_arbiter #(
    .COLS(COLS), .ROWS(ROWS), .QDEPTH(QDEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cyc = -1;
  int lastclr_cyc = -1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a plain queue of pending writes plus a sweep cursor
  typedef struct {
    logic [7:0] ch, x, y, a1, a2;
  } ent_t;

  ent_t        mq[$];
  bit          m_clear;
  int          m_caddr;
  logic [7:0]  m_ca1, m_ca2;
  bit          m_pend;
  bit          e_we, e_ovf, e_done;
  logic [11:0] e_addr;
  logic [23:0] e_data;
  bit          armed = 0;
  bit          prev_vid = 0;

  always @(posedge clk) begin
    bit     nwe, novf, ndone, popping;
    ent_t   e;
    nwe = 0; novf = 0; ndone = 0;
    prev_vid = bus.vid_active;
    if (!reset_n) begin
      mq.delete();
      m_clear = 0; m_caddr = 0; m_pend = 0;
      e_we = 0; e_ovf = 0; e_done = 0;
      e_addr = '0; e_data = '0;
      armed = 1;
    end else begin
      ndone = m_pend;
      m_pend = 0;
      if (bus.clr_req) begin
        mq.delete();
        m_clear = 1;
        m_caddr = 0;
        m_ca1 = bus.clr_attr1;
        m_ca2 = bus.clr_attr2;
        if (bus.wr_req) begin
          e = '{bus.wr_char, bus.wr_x, bus.wr_y,
                bus.wr_attr1, bus.wr_attr2};
          mq.push_back(e);
        end
      end else begin
        popping = !m_clear && mq.size() > 0 && !bus.vid_active;
        if (m_clear && !bus.vid_active) begin
          nwe = 1;
          e_addr = 12'(m_caddr);
          e_data = {m_ca2, m_ca1, 8'h20};
          if (m_caddr == NCELL - 1) begin
            m_clear = 0;
            m_pend = 1;
          end else begin
            m_caddr++;
          end
        end
        if (popping) begin
          e = mq.pop_front();
          if (int'(e.x) < COLS && int'(e.y) < ROWS) begin
            nwe = 1;
            e_addr = 12'(int'(e.y) * COLS + int'(e.x));
            e_data = {e.a2, e.a1, e.ch};
          end
        end
        if (bus.wr_req) begin
          if (mq.size() < QDEPTH) begin
            e = '{bus.wr_char, bus.wr_x, bus.wr_y,
                  bus.wr_attr1, bus.wr_attr2};
            mq.push_back(e);
          end else begin
            novf = 1;
          end
        end
      end
      e_we = nwe;
      e_ovf = novf;
      e_done = ndone;
    end
  end

  logic [35:0] wlog[$];

  always @(negedge clk) begin
    cyc++;
    if (armed) begin
      chk("ram_we", bus.ram_we, e_we);
      if (e_we) begin
        chk("ram_addr", bus.ram_addr, e_addr);
        chk("ram_data", bus.ram_data, e_data);
      end
      chk("q_full", bus.q_full, mq.size() == QDEPTH);
      chk("busy", bus.busy, m_clear || mq.size() != 0);
      chk("overflow", bus.overflow, e_ovf);
      chk("clr_done", bus.clr_done, e_done);
      if (bus.ram_we === 1'b1) begin
        chk("we_after_vid", prev_vid, 0);
        wlog.push_back({bus.ram_addr, bus.ram_data});
        if (bus.ram_addr == 12'(NCELL - 1))
          lastclr_cyc = cyc;
      end
      if (bus.clr_done === 1'b1) done_cyc = cyc;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input int x, input int y, input int ch,
                    input int a1, input int a2);
    bus.wr_req   = 1'b1;
    bus.wr_x     = 8'(x);
    bus.wr_y     = 8'(y);
    bus.wr_char  = 8'(ch);
    bus.wr_attr1 = 8'(a1);
    bus.wr_attr2 = 8'(a2);
  endtask

  task automatic clr(input int a1, input int a2);
    bus.clr_req   = 1'b1;
    bus.clr_attr1 = 8'(a1);
    bus.clr_attr2 = 8'(a2);
  endtask

  task automatic wait_done(input string nm, input int lim,
                           input bit toggle);
    int k = 0;
    while (bus.clr_done !== 1'b1 && k < lim) begin
      if (toggle) bus.vid_active = ~bus.vid_active;
      step();
      k++;
    end
    chk(nm, k < lim, 1);
    bus.vid_active = 1'b0;
  endtask

  task automatic chk_sweep(input string nm, input int base,
                           input logic [23:0] d);
    int bad = 0;
    for (int i = 0; i < NCELL; i++) begin
      if (wlog[base + i] !== {12'(i), d}) bad++;
    end
    chk(nm, bad, 0);
  endtask

  initial begin
    bus.wr_req = 0; bus.wr_char = 0; bus.wr_x = 0; bus.wr_y = 0;
    bus.wr_attr1 = 0; bus.wr_attr2 = 0;
    bus.clr_req = 0; bus.clr_attr1 = 0; bus.clr_attr2 = 0;
    bus.vid_active = 0;
    reset_n = 0;
    repeat (2) step();
    chk("rst_we", bus.ram_we, 0);
    chk("rst_addr", bus.ram_addr, 0);
    chk("rst_data", bus.ram_data, 0);
    chk("rst_full", bus.q_full, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_done", bus.clr_done, 0);
    reset_n = 1;
    step();

    // Single write, minimum latency
    wr(3, 2, 'h41, 'h0F, 'h00);
    step();
    bus.wr_req = 0;
    chk("lat_we_n1", bus.ram_we, 0);
    chk("lat_busy_n1", bus.busy, 1);
    step();
    chk("lat_we_n2", bus.ram_we, 1);
    chk("lat_addr", bus.ram_addr, 163);
    chk("lat_data", bus.ram_data, 24'h000F41);
    step();

    // Off-screen coordinates are consumed silently
    wlog.delete();
    wr(80, 0, 'h42, 1, 2);
    step();
    wr(0, 30, 'h43, 1, 2);
    step();
    bus.wr_req = 0;
    repeat (4) step();
    chk("oob_writes", wlog.size(), 0);
    chk("oob_busy", bus.busy, 0);

    // Overflow with the RAM held by video
    bus.vid_active = 1;
    for (int i = 0; i < 5; i++) begin
      wr(i, 1, 'h30 + i, i, 0);
      step();
      if (i == 3) chk("full_after_4", bus.q_full, 1);
    end
    bus.wr_req = 0;
    chk("ovf_pulse", bus.overflow, 1);
    step();
    chk("ovf_clear", bus.overflow, 0);
    wlog.delete();
    bus.vid_active = 0;
    repeat (8) step();
    chk("ovf_nwrites", wlog.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("ovf_order", wlog[i],
          {12'(80 + i), 8'h00, 8'(i), 8'(8'h30 + i)});

    // Push into a full queue in the same cycle as a pop
    bus.vid_active = 1;
    for (int i = 0; i < 4; i++) begin
      wr(10 + i, 0, 'h61 + i, 0, 0);
      step();
    end
    wlog.delete();
    bus.vid_active = 0;
    wr(20, 0, 'h7A, 3, 4);
    step();
    bus.wr_req = 0;
    chk("popfull_no_ovf", bus.overflow, 0);
    repeat (8) step();
    chk("popfull_nwrites", wlog.size(), 5);
    chk("popfull_last", wlog[4], {12'd20, 24'h04037A});

    // Full clear, RAM always free
    wlog.delete();
    clr('h07, 'h01);
    step();
    bus.clr_req = 0;
    wait_done("clr_timeout", 3000, 0);
    step();
    chk("clr_nwrites", wlog.size(), NCELL);
    chk_sweep("clr_sweep", 0, 24'h010720);
    chk("clr_done_lat", done_cyc - lastclr_cyc, 1);

    // Full clear with video stealing every other cycle
    wlog.delete();
    clr('h1E, 'h02);
    step();
    bus.clr_req = 0;
    wait_done("clrv_timeout", 6000, 1);
    step();
    chk("clrv_nwrites", wlog.size(), NCELL);
    chk_sweep("clrv_sweep", 0, 24'h021E20);

    // Clear flushes queue but keeps coincident write
    wlog.delete();
    bus.vid_active = 1;
    for (int i = 0; i < 3; i++) begin
      wr(40 + i, 3, 'h51, 0, 0);
      step();
    end
    wr(5, 5, 'h5A, 'h11, 'h22);
    clr('h07, 'h01);
    step();
    bus.wr_req = 0;
    bus.clr_req = 0;
    bus.vid_active = 0;
    wait_done("flush_timeout", 3000, 0);
    repeat (3) step();
    chk("flush_nwrites", wlog.size(), NCELL + 1);
    chk_sweep("flush_sweep", 0, 24'h010720);
    chk("flush_survivor", wlog[NCELL], {12'd405, 24'h22115A});

    // Reset in the middle of a sweep
    clr('h07, 'h01);
    step();
    bus.clr_req = 0;
    begin
      int k = 0;
      while (!(bus.ram_we === 1'b1 && bus.ram_addr == 12'd100)
             && k < 300) begin
        step();
        k++;
      end
      chk("rst_mid_reach", k < 300, 1);
    end
    done_cyc = -1;
    reset_n = 0;
    step();
    reset_n = 1;
    wlog.delete();
    repeat (2500) step();
    chk("rst_mid_writes", wlog.size(), 0);
    chk("rst_mid_done", done_cyc, -1);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_addr", bus.ram_addr, 0);
    chk("rst_mid_data", bus.ram_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
